// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder controller that steers one
// operand nibble per clock (LSB first) into an external 4-bit ripple slice,
// chains the slice carry between cycles and assembles the registered sum.
// Optional feature macro: OVERFLOW_DETECT_EN (signed overflow flag on ovf).
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic [NIB-1:0][3:0]  a_q, a_d;
  logic [NIB-1:0][3:0]  b_q, b_d;
  logic [NIB-1:0][3:0]  sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept_c;
  logic                 run_c;
  logic                 last_c;

  assign accept_c = (state_q == S_IDLE) && in_valid;
  assign run_c    = (state_q == S_RUN);
  assign last_c   = run_c && (cnt_q == CNT_W'(NIB - 1));

  // Slice drive: purely a mux of registered state, forced to zero outside RUN
  assign in_ready = (state_q == S_IDLE);
  assign add_a    = run_c ? a_q[cnt_q] : 4'h0;
  assign add_b    = run_c ? b_q[cnt_q] : 4'h0;
  assign add_cin  = run_c ? carry_q    : 1'b0;

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d         = op_a;
          b_d         = op_b;
          carry_d     = cin;
          cnt_d       = '0;
          sum_d       = '0;
          cout_d      = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[cnt_q] = add_sum;
        carry_d      = add_cout;
        cnt_d        = cnt_q + CNT_W'(1);
        if (last_c) begin
          cout_d      = add_cout;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic ovf_q, ovf_d;

  // Signed overflow: like-signed operands whose result MSB differs from them
  always_comb begin
    ovf_d = ovf_q;
    if (accept_c) begin
      ovf_d = 1'b0;
    end else if (last_c) begin
      ovf_d = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (add_sum[3] != a_q[NIB-1][3]);
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) with a behavioural
// 4-bit slice; expected results queue on accept and are checked on handshake.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  nibble_serial_adder #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // 4-bit ripple slice stand-in
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
    exp_t             e;
    logic [WIDTH:0]   full;
    full   = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
`ifdef OVERFLOW_DETECT_EN
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: compare when the result is handed over
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sum",  32'(sum),  32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  // One add; inputs driven 1 time unit after the rising edge
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input int hold, input logic keep_valid,
                        output logic [NIB-1:0] cin_trace);
    int               w;
    logic [WIDTH-1:0] sh;
    exp_t             e;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'(1));
    e         = model(a, b, c);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    cin       = c;
    out_ready = (hold == 0);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    in_valid = keep_valid;
    op_a     = WIDTH'($urandom);
    op_b     = WIDTH'($urandom);
    cin      = 1'($urandom);
    for (int k = 0; k < int'(NIB); k++) begin
      sh = a >> (4 * k);
      chk("add_a", 32'(add_a), 32'(sh[3:0]));
      sh = b >> (4 * k);
      chk("add_b", 32'(add_b), 32'(sh[3:0]));
      chk("run_rdy", 32'(in_ready), 32'(0));
      chk("run_ov", 32'(out_valid), 32'(0));
      cin_trace[k] = add_cin;
      @(posedge clk); #1;
    end
    // accept edge plus NIB RUN edges: out_valid high 5 clocks from accept
    chk("latency", 32'(out_valid), 32'(1));
    in_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_sum", 32'(sum), 32'(e.sum));
      chk("hold_cout", 32'(cout), 32'(e.cout));
      chk("hold_rdy", 32'(in_ready), 32'(0));
      chk("hold_ov", 32'(out_valid), 32'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_rdy", 32'(in_ready), 32'(1));
    chk("idle_ov", 32'(out_valid), 32'(0));
  endtask

  initial begin
    logic [NIB-1:0] tr;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_rdy",  32'(in_ready),  32'(1));
    chk("rst_ov",   32'(out_valid), 32'(0));
    chk("rst_sum",  32'(sum),       32'(0));
    chk("rst_cout", 32'(cout),      32'(0));
    chk("rst_ovf",  32'(ovf),       32'(0));
    chk("rst_adda", 32'(add_a),     32'(0));
    chk("rst_addb", 32'(add_b),     32'(0));
    chk("rst_acin", 32'(add_cin),   32'(0));
    #13 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic adds, carry ripple, cin usage
    do_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0, tr);
    do_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, tr);
    chk("ripple_cin", 32'(tr), 32'(4'b1110));
    do_add(16'h0003, 16'h0004, 1'b1, 0, 1'b0, tr);
    do_add(16'hA0F9, 16'h5F09, 1'b1, 0, 1'b1, tr);

    // Consumer stalls three clocks in DONE
    do_add(16'hBEEF, 16'h1357, 1'b0, 3, 1'b0, tr);

    // Signed overflow cases
    do_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, tr);
    do_add(16'h8000, 16'hFFFF, 1'b0, 1, 1'b0, tr);
    do_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0, tr);

    // Reset during RUN with cnt=2
    in_valid = 1'b1;
    op_a     = 16'h9ABC;
    op_b     = 16'h1111;
    cin      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_adda", 32'(add_a), 32'(4'hA));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov",   32'(out_valid), 32'(0));
    chk("arst_sum",  32'(sum),       32'(0));
    chk("arst_adda", 32'(add_a),     32'(0));
    chk("arst_addb", 32'(add_b),     32'(0));
    chk("arst_acin", 32'(add_cin),   32'(0));
    chk("arst_rdy",  32'(in_ready),  32'(1));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_add(16'h0F0F, 16'h00F1, 1'b1, 0, 1'b0, tr);

    // Random adds with random stall lengths
    for (int i = 0; i < 20; i++) begin
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom), tr);
    end

    @(posedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
